life_engine_param: RTL and testbench
====================================

// Module: life_engine_param
// PURPOSE
//  Parametrised Game of Life generation engine: holds a ROWS x COLS board and computes
//  successive generations row-serially, one row per clock. Replaces the fixed 16x16 engine
//  beneath the top level and feeds board_o to the VGA renderer and counters to the SSD driver.
//  Adds single-step or free-run control, birth counting, a stable-board flag and optional torus edges.
// PARAMETERS
//  ROWS     16          board height; cell (r,c) is board bit r*COLS+c
//  COLS     16          board width
//  CNT_W    16          width of the generation and birth counters
//  RUN_DIV  25_000_000  clocks between auto-steps in run mode; must be > ROWS+2
// PORTS
//  clk               in   1          system clock
//  reset             in   1          synchronous, active-high
//  load_en           in   1          load load_board and clear counters
//  load_board        in   ROWS*COLS  initial pattern
//  step              in   1          one-cycle pulse: compute one generation
//  run               in   1          level: auto-step every RUN_DIV clocks
//  board_o           out  ROWS*COLS  current generation
//  generation_cnt_o  out  CNT_W      generations computed since load or reset
//  birth_cnt_o       out  CNT_W      cumulative births since load or reset
//  busy_o            out  1          computation in progress
//  done_o            out  1          one-cycle pulse after each commit
//  stable_o          out  1          last commit left the board unchanged
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, row counter 0, tick counter 0, next buffer 0.
//  FSM: IDLE -> COMPUTE (ROWS cycles, row = 0..ROWS-1) -> COMMIT (1 cycle) -> IDLE.
//  Start: in IDLE, on step = 1, or on the run tick (see below). Step/tick outside IDLE are dropped.
//  COMPUTE: row r of the next buffer is computed from board_o, which stays frozen during COMPUTE.
//   Cell rule: alive if n==3, or if alive and n==2; n = live 8-neighbour count (0..8).
//   births_acc += popcount(next_row & ~cur_row).
//  COMMIT: board_o <= next; generation_cnt_o += 1 (wraps modulo 2^CNT_W);
//   birth_cnt_o += births_acc, saturating at all-ones; stable_o <= (next == board_o).
//  Latency: start sampled at cycle t; busy_o = 1 for cycles t+1..t+ROWS+1.
//   New board_o and done_o = 1 are visible at cycle t+ROWS+2.
//  Run: the tick counter counts while run = 1 and clears to 0 while run = 0.
//   At RUN_DIV-1 it issues a tick and returns to 0. A tick and step in the same cycle start one generation.
//  load_en (any state): board_o <= load_board; both counters, stable_o and births_acc <= 0;
//   FSM -> IDLE, aborting any computation with no commit and no done_o. Has priority over step and tick.
//  Reset during COMPUTE/COMMIT: full reset; no commit occurs.
//  Edges: handled by the macro below. All-dead board: stays dead, stable_o = 1 after its first commit.
// CONFIGURATION
//  LIFE_TORUS_EN defined: neighbours wrap toroidally (row -1 -> ROWS-1, col COLS -> 0, etc.).
//  LIFE_TORUS_EN undefined: cells outside the board count as dead; no wrap logic synthesised.
// TESTING
//  1 Blinker: horizontal 3-cell at row 7, cols 6..8; step -> vertical at col 7, rows 6..8;
//    gen = 1, births = 2, done_o at t+18. Second step -> original pattern, gen = 2, births = 4.
//  2 Block still life at (4,4): step -> board unchanged, stable_o = 1, births = 0.
//  3 Glider at the bottom-right corner, 8 steps. With LIFE_TORUS_EN it reappears at the top-left.
//    Without the macro it decays into a block at the corner.
//  4 RUN_DIV = 32, run held high for 200 clocks -> exactly 6 done_o pulses, 32 clocks apart.
//  5 load_en asserted at cycle t+5 of COMPUTE -> busy_o = 0 next cycle, no done_o,
//    board_o = load_board, counters 0.
//  6 CNT_W = 4, blinker, 17 steps -> gen wraps to 1; birth_cnt_o saturates at 15.

Source files
------------

// File: rtl/life_engine_param_if.sv
// Control/status bundle for the Game of Life engine: the master drives load/step/run,
// the slave (engine) returns the board, counters and status flags.
interface life_engine_param_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 16
);
    logic                   load_en;
    logic [ROWS*COLS-1:0]   load_board;
    logic                   step;
    logic                   run;
    logic [ROWS*COLS-1:0]   board_o;
    logic [CNT_W-1:0]       generation_cnt_o;
    logic [CNT_W-1:0]       birth_cnt_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   stable_o;

    modport master (
        output load_en, load_board, step, run,
        input  board_o, generation_cnt_o, birth_cnt_o, busy_o, done_o, stable_o
    );

    modport slave (
        input  load_en, load_board, step, run,
        output board_o, generation_cnt_o, birth_cnt_o, busy_o, done_o, stable_o
    );
endinterface

// File: rtl/life_engine_param.sv
// Row-serial Game of Life engine: one board row of the next generation per clock.
// Define LIFE_TORUS_EN to wrap neighbours toroidally; otherwise off-board cells are dead.
module life_cell (
    input  logic [8:0] win,
    output logic       alive
);
    logic [3:0] n;

    always_comb begin
        n = '0;
        for (int i = 0; i < 9; i++)
            if (i != 4) n = n + {3'b0, win[i]};
        alive = (n == 4'd3) || (win[4] && (n == 4'd2));
    end
endmodule

module life_engine_param #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int CNT_W   = 16,
    parameter int RUN_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    life_engine_param_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int BW = $clog2(N + 1);
    localparam int SW = ((CNT_W > BW) ? CNT_W : BW) + 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

    state_t                 state, state_n;
    logic [RW-1:0]          row;
    logic [TW-1:0]          tick_cnt;
    logic                   tick, start;
    logic [N-1:0]           board, next_buf;
    logic [CNT_W-1:0]       gen_cnt, birth_cnt;
    logic [BW-1:0]          births_acc;
    logic                   done, stable;
    logic [COLS-1:0]        up_row, cur_row, dn_row, new_row;
    logic [COLS+1:0]        up_ext, cur_ext, dn_ext;
    logic [COLS-1:0][8:0]   win;
    logic [SW-1:0]          bsum;

    assign tick  = bus.run && (tick_cnt == TW'(RUN_DIV - 1));
    assign start = (state == IDLE) && !bus.load_en && (bus.step || tick);
    assign bsum  = SW'(birth_cnt) + SW'(births_acc);

    // Neighbourhood rows are taken from the committed board, which stays frozen while computing.
    always_comb begin
        cur_row = board[int'(row)*COLS +: COLS];
        up_row  = '0;
        dn_row  = '0;
        if (row != '0)
            up_row = board[(int'(row) - 1)*COLS +: COLS];
        if (int'(row) != ROWS - 1)
            dn_row = board[(int'(row) + 1)*COLS +: COLS];
`ifdef LIFE_TORUS_EN
        if (row == '0)
            up_row = board[(ROWS - 1)*COLS +: COLS];
        if (int'(row) == ROWS - 1)
            dn_row = board[0 +: COLS];
        up_ext  = {up_row[0],  up_row,  up_row[COLS-1]};
        cur_ext = {cur_row[0], cur_row, cur_row[COLS-1]};
        dn_ext  = {dn_row[0],  dn_row,  dn_row[COLS-1]};
`else
        up_ext  = {1'b0, up_row,  1'b0};
        cur_ext = {1'b0, cur_row, 1'b0};
        dn_ext  = {1'b0, dn_row,  1'b0};
`endif
    end

    // ext bit c+1 is column c, so the 3x3 window of column c is ext[c+2:c] with the centre at bit 4.
    for (genvar c = 0; c < COLS; c++) begin : g_cell
        assign win[c] = {dn_ext[c+2:c], cur_ext[c+2:c], up_ext[c+2:c]};
        life_cell u_cell (.win(win[c]), .alive(new_row[c]));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.step || tick)            state_n = COMPUTE;
            COMPUTE: if (int'(row) == ROWS - 1)       state_n = COMMIT;
            COMMIT:                                   state_n = IDLE;
            default:                                  state_n = IDLE;
        endcase
        if (bus.load_en) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.run || tick) tick_cnt <= '0;
        else                           tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row        <= '0;
            board      <= '0;
            next_buf   <= '0;
            gen_cnt    <= '0;
            birth_cnt  <= '0;
            births_acc <= '0;
            done       <= 1'b0;
            stable     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == COMPUTE && int'(row) != ROWS - 1) row <= row + 1'b1;
            else                                           row <= '0;
            if (bus.load_en) begin
                board      <= bus.load_board;
                gen_cnt    <= '0;
                birth_cnt  <= '0;
                births_acc <= '0;
                stable     <= 1'b0;
                row        <= '0;
            end else begin
                unique case (state)
                    IDLE: if (start) births_acc <= '0;
                    COMPUTE: begin
                        next_buf[int'(row)*COLS +: COLS] <= new_row;
                        births_acc <= births_acc + BW'($countones(new_row & ~cur_row));
                    end
                    COMMIT: begin
                        board     <= next_buf;
                        gen_cnt   <= gen_cnt + 1'b1;
                        birth_cnt <= (bsum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : bsum[CNT_W-1:0];
                        stable    <= (next_buf == board);
                        done      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.board_o          = board;
    assign bus.generation_cnt_o = gen_cnt;
    assign bus.birth_cnt_o      = birth_cnt;
    assign bus.busy_o           = (state != IDLE);
    assign bus.done_o           = done;
    assign bus.stable_o         = stable;
endmodule

// File: tb/tb_life_engine_param.sv
// Directed bench for life_engine_param: 16x16 board with RUN_DIV=32, plus a CNT_W=4 copy for wrap/saturation.
module tb_life_engine_param;
    localparam int R = 16;
    localparam int C = 16;
    localparam int N = R * C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    life_engine_param_if #(.ROWS(R), .COLS(C), .CNT_W(16)) bus ();
    life_engine_param_if #(.ROWS(R), .COLS(C), .CNT_W(4))  bus4 ();

    life_engine_param #(.ROWS(R), .COLS(C), .CNT_W(16), .RUN_DIV(32)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    life_engine_param #(.ROWS(R), .COLS(C), .CNT_W(4), .RUN_DIV(32)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4));

    function automatic int idx(input int r, input int c);
        return r * C + c;
    endfunction

    logic [N-1:0] blink_h, blink_v, block, glider, glider_end;

    task automatic load(input logic [N-1:0] b);
        @(negedge clk); bus.load_board = b; bus.load_en = 1'b1;
        @(negedge clk); bus.load_en = 1'b0;
    endtask

    // Returns the number of negedges from raising step until done_o is seen (-1 on timeout).
    task automatic do_step(output int lat, output logic busy1);
        lat = -1; busy1 = 1'b0;
        @(negedge clk); bus.step = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk); bus.step = 1'b0;
            if (k == 1) busy1 = bus.busy_o;
            if (bus.done_o) begin lat = k; break; end
        end
    endtask

    task automatic do_step4(output int lat);
        lat = -1;
        @(negedge clk); bus4.step = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk); bus4.step = 1'b0;
            if (bus4.done_o) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks += 6;
        if (bus.board_o !== '0) begin errors++; $display("FAIL reset_board got %h want 0", bus.board_o); end
        if (bus.generation_cnt_o !== '0) begin errors++; $display("FAIL reset_gen got %0d want 0", bus.generation_cnt_o); end
        if (bus.birth_cnt_o !== '0) begin errors++; $display("FAIL reset_birth got %0d want 0", bus.birth_cnt_o); end
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        if (bus.stable_o !== 1'b0) begin errors++; $display("FAIL reset_stable got %b want 0", bus.stable_o); end
        reset = 1'b0;
    endtask

    task automatic test_blinker;
        int lat; logic b1;
        load(blink_h);
        do_step(lat, b1);
        checks += 6;
        if (lat !== 18) begin errors++; $display("FAIL blink_latency got %0d want 18", lat); end
        if (b1 !== 1'b1) begin errors++; $display("FAIL blink_busy got %b want 1", b1); end
        if (bus.board_o !== blink_v) begin errors++; $display("FAIL blink_board1 got %h want %h", bus.board_o, blink_v); end
        if (bus.generation_cnt_o !== 16'd1) begin errors++; $display("FAIL blink_gen1 got %0d want 1", bus.generation_cnt_o); end
        if (bus.birth_cnt_o !== 16'd2) begin errors++; $display("FAIL blink_birth1 got %0d want 2", bus.birth_cnt_o); end
        if (bus.stable_o !== 1'b0) begin errors++; $display("FAIL blink_stable got %b want 0", bus.stable_o); end
        do_step(lat, b1);
        checks += 3;
        if (bus.board_o !== blink_h) begin errors++; $display("FAIL blink_board2 got %h want %h", bus.board_o, blink_h); end
        if (bus.generation_cnt_o !== 16'd2) begin errors++; $display("FAIL blink_gen2 got %0d want 2", bus.generation_cnt_o); end
        if (bus.birth_cnt_o !== 16'd4) begin errors++; $display("FAIL blink_birth2 got %0d want 4", bus.birth_cnt_o); end
    endtask

    task automatic test_block;
        int lat; logic b1;
        load(block);
        do_step(lat, b1);
        checks += 4;
        if (lat !== 18) begin errors++; $display("FAIL block_latency got %0d want 18", lat); end
        if (bus.board_o !== block) begin errors++; $display("FAIL block_board got %h want %h", bus.board_o, block); end
        if (bus.stable_o !== 1'b1) begin errors++; $display("FAIL block_stable got %b want 1", bus.stable_o); end
        if (bus.birth_cnt_o !== 16'd0) begin errors++; $display("FAIL block_birth got %0d want 0", bus.birth_cnt_o); end
    endtask

    task automatic test_glider;
        int lat; logic b1;
        logic [15:0] exp_births;
        logic        exp_stable;
`ifdef LIFE_TORUS_EN
        exp_births = 16'd16; exp_stable = 1'b0;
`else
        exp_births = 16'd2;  exp_stable = 1'b1;
`endif
        load(glider);
        for (int s = 0; s < 8; s++) do_step(lat, b1);
        checks += 4;
        if (bus.board_o !== glider_end) begin errors++; $display("FAIL glider_board got %h want %h", bus.board_o, glider_end); end
        if (bus.generation_cnt_o !== 16'd8) begin errors++; $display("FAIL glider_gen got %0d want 8", bus.generation_cnt_o); end
        if (bus.birth_cnt_o !== exp_births) begin errors++; $display("FAIL glider_birth got %0d want %0d", bus.birth_cnt_o, exp_births); end
        if (bus.stable_o !== exp_stable) begin errors++; $display("FAIL glider_stable got %b want %b", bus.stable_o, exp_stable); end
    endtask

    task automatic test_run;
        int nd; int t[8];
        nd = 0;
        for (int i = 0; i < 8; i++) t[i] = 0;
        load(blink_h);
        @(negedge clk); bus.run = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (k == 200) bus.run = 1'b0;
            if (bus.done_o) begin
                if (nd < 8) t[nd] = k;
                nd++;
            end
        end
        checks += 2;
        if (nd !== 6) begin errors++; $display("FAIL run_count got %0d want 6", nd); end
        if (t[0] !== 49) begin errors++; $display("FAIL run_first got %0d want 49", t[0]); end
        for (int i = 1; i < 6; i++) begin
            checks++;
            if (t[i] - t[i-1] !== 32) begin errors++; $display("FAIL run_gap%0d got %0d want 32", i, t[i] - t[i-1]); end
        end
        checks++;
        if (bus.generation_cnt_o !== 16'd6) begin errors++; $display("FAIL run_gen got %0d want 6", bus.generation_cnt_o); end
    endtask

    task automatic test_load_abort;
        int lat; logic b1; logic seen;
        seen = 1'b0;
        load(blink_h);
        do_step(lat, b1);
        @(negedge clk); bus.step = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); bus.step = 1'b0;
        end
        bus.load_board = block; bus.load_en = 1'b1;
        @(negedge clk); bus.load_en = 1'b0;
        checks += 4;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy_o); end
        if (bus.board_o !== block) begin errors++; $display("FAIL abort_board got %h want %h", bus.board_o, block); end
        if (bus.generation_cnt_o !== 16'd0) begin errors++; $display("FAIL abort_gen got %0d want 0", bus.generation_cnt_o); end
        if (bus.birth_cnt_o !== 16'd0) begin errors++; $display("FAIL abort_birth got %0d want 0", bus.birth_cnt_o); end
        for (int k = 0; k < 25; k++) begin
            if (bus.done_o) seen = 1'b1;
            @(negedge clk);
        end
        checks += 2;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", seen); end
        if (bus.board_o !== block) begin errors++; $display("FAIL abort_hold got %h want %h", bus.board_o, block); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        seen = 1'b0;
        load(blink_h);
        @(negedge clk); bus.step = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); bus.step = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks += 2;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy_o); end
        if (bus.board_o !== '0) begin errors++; $display("FAIL rmid_board got %h want 0", bus.board_o); end
        for (int k = 0; k < 25; k++) begin
            if (bus.done_o) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", seen); end
    endtask

    task automatic test_cnt_wrap;
        int lat;
        @(negedge clk); bus4.load_board = blink_h; bus4.load_en = 1'b1;
        @(negedge clk); bus4.load_en = 1'b0;
        for (int s = 0; s < 17; s++) do_step4(lat);
        checks += 4;
        if (lat !== 18) begin errors++; $display("FAIL wrap_latency got %0d want 18", lat); end
        if (bus4.generation_cnt_o !== 4'd1) begin errors++; $display("FAIL wrap_gen got %0d want 1", bus4.generation_cnt_o); end
        if (bus4.birth_cnt_o !== 4'd15) begin errors++; $display("FAIL wrap_birth got %0d want 15", bus4.birth_cnt_o); end
        if (bus4.board_o !== blink_v) begin errors++; $display("FAIL wrap_board got %h want %h", bus4.board_o, blink_v); end
    endtask

    initial begin
        bus.load_en = 1'b0;  bus.load_board = '0;  bus.step = 1'b0;  bus.run = 1'b0;
        bus4.load_en = 1'b0; bus4.load_board = '0; bus4.step = 1'b0; bus4.run = 1'b0;

        blink_h = '0; blink_h[idx(7,6)] = 1'b1; blink_h[idx(7,7)] = 1'b1; blink_h[idx(7,8)] = 1'b1;
        blink_v = '0; blink_v[idx(6,7)] = 1'b1; blink_v[idx(7,7)] = 1'b1; blink_v[idx(8,7)] = 1'b1;
        block = '0;   block[idx(4,4)] = 1'b1; block[idx(4,5)] = 1'b1; block[idx(5,4)] = 1'b1; block[idx(5,5)] = 1'b1;
        glider = '0;  glider[idx(13,14)] = 1'b1; glider[idx(14,15)] = 1'b1;
        glider[idx(15,13)] = 1'b1; glider[idx(15,14)] = 1'b1; glider[idx(15,15)] = 1'b1;
        glider_end = '0;
`ifdef LIFE_TORUS_EN
        // Eight generations move the glider two cells down and right, wrapping to the top-left.
        glider_end[idx(15,0)] = 1'b1; glider_end[idx(0,1)] = 1'b1;
        glider_end[idx(1,15)] = 1'b1; glider_end[idx(1,0)] = 1'b1; glider_end[idx(1,1)] = 1'b1;
`else
        glider_end[idx(14,14)] = 1'b1; glider_end[idx(14,15)] = 1'b1;
        glider_end[idx(15,14)] = 1'b1; glider_end[idx(15,15)] = 1'b1;
`endif

        test_reset;
        test_blinker;
        test_block;
        test_glider;
        test_run;
        test_load_abort;
        test_reset_mid;
        test_cnt_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
